// File: rtl/display_scan_mux_if.sv
// ----------------------------------------------------------------------------
// display_scan_mux_if
//
// Bundles the panel-facing signals of the display scanner.
//
//   enable      scanning runs when 1; display dark and state frozen when 0
//   mode_sel    0 = source A (drink), 1 = source B (sensor)
//   digits_a    source A hex nibbles, digit i = bits [4i+3:4i]
//   digits_b    source B hex nibbles, same packing
//   blank_mask  1 = digit i always dark
//   blink_mask  1 = digit i dark during the blink-off phase
//   an          digit select pins (one-hot when active)
//   seg         segment pins {a,b,c,d,e,f,g}, seg[6] = a
//   frame_tick  one-cycle pulse per completed frame
//
// The master modport is the control side (drink/sensor logic). The slave
// modport is the scanner itself.
// ----------------------------------------------------------------------------
interface display_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      mode_sel;
    logic [4*NUM_DIGITS-1:0]   digits_a;
    logic [4*NUM_DIGITS-1:0]   digits_b;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      frame_tick;

    modport master (
        output enable,
        output mode_sel,
        output digits_a,
        output digits_b,
        output blank_mask,
        output blink_mask,
        input  an,
        input  seg,
        input  frame_tick
    );

    modport slave (
        input  enable,
        input  mode_sel,
        input  digits_a,
        input  digits_b,
        input  blank_mask,
        input  blink_mask,
        output an,
        output seg,
        output frame_tick
    );
endinterface

// File: rtl/display_scan_mux.sv
// ----------------------------------------------------------------------------
// display_scan_mux
//
// Time-multiplexed 7-segment scanner for the dispenser front panel. Each
// digit owns a slot of PRESCALE clk cycles. The first cycle of every slot is
// a dead cycle (no anode, no segments) so the previous digit's pattern never
// ghosts onto the next anode. The source (drink or sensor) is latched once
// per frame, so a mode change never tears a frame. Blinking toggles every
// BLINK_FRAMES frames.
//
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   display_scan_mux_if.slave: enable, mode_sel, digits_a/b,
//         blank_mask, blink_mask in; an, seg, frame_tick out
//
// an/seg/frame_tick are registered and lag the scan state by one cycle.
// ----------------------------------------------------------------------------
module display_scan_mux #(
    parameter int NUM_DIGITS     = 4,      // 2..8
    parameter int PRESCALE       = 50000,  // clk cycles per digit slot, >= 2
    parameter int SEG_ACTIVE_LOW = 1,      // 1 = segment lit when pin low
    parameter int AN_ACTIVE_LOW  = 1,      // 1 = digit selected when pin low
    parameter int BLINK_FRAMES   = 64      // frames per blink half-period, >= 1
) (
    input  logic               clk,
    input  logic               rst,
    display_scan_mux_if.slave  bus
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    // Pin levels for "not selected" and "not lit". XOR-ing a logical
    // (active-high) pattern with these yields the pin pattern.
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0] SEG_OFF =
        (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    // ------------------------------------------------------------------------
    // Hex to logical segment pattern {a,b,c,d,e,f,g}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1111110;
            4'h1:    pat = 7'b0110000;
            4'h2:    pat = 7'b1101101;
            4'h3:    pat = 7'b1111001;
            4'h4:    pat = 7'b0110011;
            4'h5:    pat = 7'b1011011;
            4'h6:    pat = 7'b1011111;
            4'h7:    pat = 7'b1110000;
            4'h8:    pat = 7'b1111111;
            4'h9:    pat = 7'b1111011;
            4'hA:    pat = 7'b1110111;
            4'hB:    pat = 7'b0011111;
            4'hC:    pat = 7'b1001110;
            4'hD:    pat = 7'b0111101;
            4'hE:    pat = 7'b1001111;
            default: pat = 7'b1000111;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------------
    logic [CW-1:0]         cnt_q,  cnt_d;
    logic [IW-1:0]         idx_q,  idx_d;
    logic                  mode_q, mode_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  blink_ph_q, blink_ph_d;

    logic [NUM_DIGITS-1:0] an_q,  an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  lit;
    logic [3:0]            nibble;
    logic [NUM_DIGITS-1:0] onehot;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Next-state logic for the counters and per-frame latches.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        fcnt_d     = fcnt_q;
        blink_ph_d = blink_ph_q;

        if (bus.enable) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end

            // Source and blink phase only change between frames, so a
            // frame is always drawn from one consistent source.
            if (frame_end) begin
                mode_d = bus.mode_sel;
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d     = '0;
                    blink_ph_d = ~blink_ph_q;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end
    end

    // Output decode from the current state; registered below.
    always_comb begin
        nibble = mode_q ? bus.digits_b[{idx_q, 2'b00} +: 4]
                        : bus.digits_a[{idx_q, 2'b00} +: 4];
        onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

        // cnt_q == 0 is the anti-ghosting dead cycle. Blanking wins over
        // blinking simply because either one darkens the digit.
        lit = (cnt_q != '0)
              && bus.enable
              && !bus.blank_mask[idx_q]
              && !(blink_ph_q && bus.blink_mask[idx_q]);

        an_d         = lit ? (onehot ^ AN_OFF) : AN_OFF;
        seg_d        = lit ? (hex_decode(nibble) ^ SEG_OFF) : SEG_OFF;
        frame_tick_d = bus.enable && frame_end;
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // races between the flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            mode_q       <= 1'b0;
            fcnt_q       <= '0;
            blink_ph_q   <= 1'b0;
            // NOTE: pins are reset to their inactive levels, not to zero, so
            // the panel is dark immediately on reset for either polarity.
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            fcnt_q       <= fcnt_d;
            blink_ph_q   <= blink_ph_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// ----------------------------------------------------------------------------
// tb_display_scan_mux
//
// Directed bench for display_scan_mux with NUM_DIGITS=4, PRESCALE=4,
// BLINK_FRAMES=2, both polarities active-low. Outputs are sampled 2 time
// units after each rising edge. Edge k (1-based, counted from reset release)
// processes scan state s = k-1: cnt = s%4, digit = (s/4)%4, frame = s/16.
// ----------------------------------------------------------------------------
module tb_display_scan_mux;

    localparam int ND = 4;
    localparam int PS = 4;
    localparam int BF = 2;

    localparam logic [15:0] SRC_A = 16'h4321;
    localparam logic [15:0] SRC_B = 16'hFEDC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    display_scan_mux #(
        .NUM_DIGITS    (ND),
        .PRESCALE      (PS),
        .SEG_ACTIVE_LOW(1),
        .AN_ACTIVE_LOW (1),
        .BLINK_FRAMES  (BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Logical segment table, hand-copied from the panel's hex font.
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1111110;  4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;  4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;  4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;  4'h7: p = 7'b1110000;
            4'h8: p = 7'b1111111;  4'h9: p = 7'b1111011;
            4'hA: p = 7'b1110111;  4'hB: p = 7'b0011111;
            4'hC: p = 7'b1001110;  4'hD: p = 7'b0111101;
            4'hE: p = 7'b1001111;  default: p = 7'b1000111;
        endcase
        return p;
    endfunction

    // Expected pins after edge k since reset release, derived from elapsed
    // time. Source B applies from frame b_frame onwards.
    function automatic void expect_at(input int k, input logic [3:0] blank,
                                      input logic [3:0] blink, input int b_frame,
                                      output logic [3:0] an_e,
                                      output logic [6:0] seg_e,
                                      output logic ft_e);
        int s, c, d, f;
        logic ph, on;
        logic [15:0] src;
        logic [3:0]  nib;
        s  = k - 1;
        c  = s % PS;
        d  = (s / PS) % ND;
        f  = s / (PS * ND);
        ph = ((f / BF) % 2) == 1;
        src = (f >= b_frame) ? SRC_B : SRC_A;
        nib = src[d*4 +: 4];
        on  = (c != 0) && !blank[d] && !(ph && blink[d]);
        an_e  = on ? ~(4'b0001 << d) : 4'b1111;
        seg_e = on ? ~font(nib) : 7'b1111111;
        ft_e  = (k % (PS * ND)) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves rst released 2 units after a rising edge; the next edge is edge 1.
    task automatic restart();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs edges k_from..k_to comparing all pins against expect_at.
    task automatic run_model(input string tag, input int k_from, input int k_to,
                             input logic [3:0] blank, input logic [3:0] blink,
                             input int b_frame);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       ft_e;
        for (int k = k_from; k <= k_to; k++) begin
            tick();
            expect_at(k, blank, blink, b_frame, an_e, seg_e, ft_e);
            checks++;
            if (bus.an !== an_e || bus.seg !== seg_e || bus.frame_tick !== ft_e) begin
                errors++;
                $display("FAIL %s edge %0d: an=%b seg=%b ft=%b expected an=%b seg=%b ft=%b",
                         tag, k, bus.an, bus.seg, bus.frame_tick, an_e, seg_e, ft_e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.an !== 4'b1111) begin
            errors++; $display("FAIL reset_an: got %b expected 1111", bus.an);
        end
        checks++;
        if (bus.seg !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg: got %b expected 1111111", bus.seg);
        end
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b expected 0", bus.frame_tick);
        end
    endtask

    task automatic test_release_sequence();
        restart();
        tick();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin
            errors++; $display("FAIL first_dead: an=%b seg=%b expected 1111/1111111", bus.an, bus.seg);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.an !== 4'b1110 || bus.seg !== 7'b1001111) begin
                errors++; $display("FAIL digit0_lit[%0d]: an=%b seg=%b expected 1110/1001111", i, bus.an, bus.seg);
            end
        end
        tick();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin
            errors++; $display("FAIL slot1_dead: an=%b seg=%b expected 1111/1111111", bus.an, bus.seg);
        end
        tick();
        checks++;
        if (bus.an !== 4'b1101 || bus.seg !== 7'b0010010) begin
            errors++; $display("FAIL digit1_lit: an=%b seg=%b expected 1101/0010010", bus.an, bus.seg);
        end
    endtask

    task automatic test_frame_tick();
        restart();
        for (int k = 1; k <= 48; k++) begin
            tick();
            checks++;
            if (bus.frame_tick !== ((k % 16) == 0)) begin
                errors++;
                $display("FAIL frame_tick edge %0d: got %b expected %b", k, bus.frame_tick, (k % 16) == 0);
            end
        end
    endtask

    task automatic test_mode_switch();
        restart();
        run_model("mode_pre", 1, 5, 4'b0000, 4'b0000, 99);
        bus.mode_sel = 1'b1;   // digit 1 is on screen now
        run_model("mode_switch", 6, 17, 4'b0000, 4'b0000, 1);
        tick();                // edge 18: first lit cycle of digit 0, frame 1
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'b0110001) begin
            errors++; $display("FAIL mode_digit0_C: an=%b seg=%b expected 1110/0110001", bus.an, bus.seg);
        end
        run_model("mode_post", 19, 32, 4'b0000, 4'b0000, 1);
        bus.mode_sel = 1'b0;
    endtask

    task automatic test_blank();
        bus.blank_mask = 4'b0010;
        restart();
        run_model("blank", 1, 32, 4'b0010, 4'b0000, 99);
        bus.blank_mask = 4'b0000;
    endtask

    task automatic test_blink();
        int lit0;
        bus.blink_mask = 4'b0001;
        restart();
        run_model("blink", 1, 96, 4'b0000, 4'b0001, 99);

        bus.blank_mask = 4'b0001;
        restart();
        lit0 = 0;
        for (int k = 1; k <= 96; k++) begin
            tick();
            if (bus.an[0] === 1'b0) lit0++;
        end
        checks++;
        if (lit0 !== 0) begin
            errors++; $display("FAIL blank_over_blink: digit0 lit %0d cycles expected 0", lit0);
        end
        bus.blank_mask = 4'b0000;
        bus.blink_mask = 4'b0000;
    endtask

    task automatic test_enable_and_async_reset();
        restart();
        // Through edge 11: digit 2 has shown cnt=1,2; state is now cnt=3.
        run_model("en_pre", 1, 11, 4'b0000, 4'b0000, 99);
        bus.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 || bus.frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL disabled[%0d]: an=%b seg=%b ft=%b expected 1111/1111111/0",
                         i, bus.an, bus.seg, bus.frame_tick);
            end
        end
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.an !== 4'b1011 || bus.seg !== 7'b0000110) begin
            errors++; $display("FAIL resume_digit2: an=%b seg=%b expected 1011/0000110", bus.an, bus.seg);
        end
        tick();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin
            errors++; $display("FAIL resume_dead: an=%b seg=%b expected 1111/1111111", bus.an, bus.seg);
        end
        tick();
        checks++;
        if (bus.an !== 4'b0111 || bus.seg !== 7'b1001100) begin
            errors++; $display("FAIL resume_digit3: an=%b seg=%b expected 0111/1001100", bus.an, bus.seg);
        end
        tick();
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++; $display("FAIL resume_tick_early: got %b expected 0", bus.frame_tick);
        end
        tick();
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            errors++; $display("FAIL resume_tick: got %b expected 1", bus.frame_tick);
        end
        tick();        // dead cycle of digit 0
        tick();        // digit 0 lit
        checks++;
        if (bus.an !== 4'b1110) begin
            errors++; $display("FAIL pre_rst_lit: an=%b expected 1110", bus.an);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin
            errors++; $display("FAIL async_rst: an=%b seg=%b expected 1111/1111111", bus.an, bus.seg);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.an !== 4'b1111) begin
            errors++; $display("FAIL post_rst_dead: an=%b expected 1111", bus.an);
        end
        tick();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'b1001111) begin
            errors++; $display("FAIL post_rst_digit0: an=%b seg=%b expected 1110/1001111", bus.an, bus.seg);
        end
    endtask

    initial begin
        bus.enable     = 1'b1;
        bus.mode_sel   = 1'b0;
        bus.digits_a   = SRC_A;
        bus.digits_b   = SRC_B;
        bus.blank_mask = 4'b0000;
        bus.blink_mask = 4'b0000;

        test_reset();
        test_release_sequence();
        test_frame_tick();
        test_mode_switch();
        test_blank();
        test_blink();
        test_enable_and_async_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
